// File: rtl/pipe_sequencer.sv
// Pipeline stall/flush sequencer for the 5-stage MIPS core: per-stage enables, bubbles, stall watchdog.
// Optional performance counters are enabled with `define PIPE_SEQ_PERF_EN.
module pipe_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             wdog_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HAZ   = 2'd1,
    MEMW  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_LIMIT  = 8'(MAX_STALL);
  localparam state_t     BRANCH_NXT   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t     state_r, state_nxt_s;
  logic [1:0] flush_left_r, flush_left_nxt_s;
  logic [7:0] haz_cnt_r, haz_cnt_nxt_s;
  logic       wdog_set_s;

  // Output decode and next-state selection; reset forces plain run outputs.
  always_comb begin
    pc_en            = 1'b1;
    ifid_en          = 1'b1;
    ifid_flush       = 1'b0;
    idex_flush       = 1'b0;
    exmem_en         = 1'b1;
    memwb_en         = 1'b1;
    state_nxt_s      = RUN;
    flush_left_nxt_s = flush_left_r;
    haz_cnt_nxt_s    = haz_cnt_r;
    wdog_set_s       = 1'b0;
    if (!reset) begin
      state_nxt_s = RUN;
    end else if (mem_busy) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      state_nxt_s = MEMW;
    end else begin
      case (state_r)
        RUN, HAZ: begin
          if (branch_taken) begin
            ifid_flush       = 1'b1;
            idex_flush       = 1'b1;
            state_nxt_s      = BRANCH_NXT;
            flush_left_nxt_s = FLUSH_RELOAD;
            haz_cnt_nxt_s    = 8'd0;
          end else if (hazard_stall && (state_r == RUN || haz_cnt_r < STALL_LIMIT)) begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            idex_flush    = 1'b1;
            state_nxt_s   = HAZ;
            haz_cnt_nxt_s = (state_r == RUN) ? 8'd1 : haz_cnt_r + 8'd1;
          end else begin
            // Stall ended or watchdog forced a release of a stuck stall.
            wdog_set_s    = hazard_stall && (state_r == HAZ);
            haz_cnt_nxt_s = 8'd0;
            state_nxt_s   = RUN;
          end
        end
        MEMW: begin
          state_nxt_s = RUN;
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (branch_taken) begin
            flush_left_nxt_s = FLUSH_RELOAD;
            state_nxt_s      = BRANCH_NXT;
          end else if (flush_left_r <= 2'd1) begin
            flush_left_nxt_s = 2'd0;
            state_nxt_s      = RUN;
          end else begin
            flush_left_nxt_s = flush_left_r - 2'd1;
            state_nxt_s      = FLUSH;
          end
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // FSM state, sequencing counters and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= RUN;
      flush_left_r <= 2'd0;
      haz_cnt_r    <= 8'd0;
      wdog_err     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      flush_left_r <= flush_left_nxt_s;
      haz_cnt_r    <= haz_cnt_nxt_s;
      wdog_err     <= wdog_err | wdog_set_s;
    end
  end

`ifdef PIPE_SEQ_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating stall and flush performance counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (ifid_flush && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer; two instances cover FLUSH_CYCLES=2 and FLUSH_CYCLES=3.
module tb_pipe_sequencer;

  // Output bundle order: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_en}
  localparam logic [5:0] RUN_O    = 6'b110011;
  localparam logic [5:0] STALL_O  = 6'b000111;
  localparam logic [5:0] FLUSH_O  = 6'b111111;
  localparam logic [5:0] FREEZE_O = 6'b000000;
`ifdef PIPE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, hazard_stall, branch_taken, mem_busy;
  wire [5:0]  o2, o3;
  wire        wd2, wd3;
  wire [15:0] sc2, fc2, sc3, fc3;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_sequencer #(.FLUSH_CYCLES(2), .MAX_STALL(8), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_en(o2[5]), .ifid_en(o2[4]), .ifid_flush(o2[3]),
    .idex_flush(o2[2]), .exmem_en(o2[1]), .memwb_en(o2[0]), .wdog_err(wd2),
    .stall_cnt(sc2), .flush_cnt(fc2));

  pipe_sequencer #(.FLUSH_CYCLES(3), .MAX_STALL(8), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_en(o3[5]), .ifid_en(o3[4]), .ifid_flush(o3[3]),
    .idex_flush(o3[2]), .exmem_en(o3[1]), .memwb_en(o3[0]), .wdog_err(wd3),
    .stall_cnt(sc3), .flush_cnt(fc3));

  function automatic logic [31:0] ecnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic drive(input logic r, input logic h, input logic b, input logic m);
    @(negedge clk);
    reset        = r;
    hazard_stall = h;
    branch_taken = b;
    mem_busy     = m;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; hazard_stall = 1'b1; branch_taken = 1'b1; mem_busy = 1'b1;
    // reset overrides every request
    drive(1'b0, 1'b1, 1'b1, 1'b1); chk("rst_out", 32'(o2), 32'(RUN_O));
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("idle_out", 32'(o2), 32'(RUN_O));
    chk("rst_sc", 32'(sc2), 32'd0); chk("rst_fc", 32'(fc2), 32'd0); chk("rst_wd", 32'(wd2), 32'd0);

    // two-cycle hazard stall
    drive(1'b1, 1'b1, 1'b0, 1'b0); chk("haz1", 32'(o2), 32'(STALL_O));
    drive(1'b1, 1'b1, 1'b0, 1'b0); chk("haz2", 32'(o2), 32'(STALL_O));
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("haz_resume", 32'(o2), 32'(RUN_O));
    chk("haz_sc", 32'(sc2), ecnt(2));
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("haz_idle", 32'(o2), 32'(RUN_O));

    // single branch: 2 flush cycles on u2, 3 on u3
    drive(1'b1, 1'b0, 1'b1, 1'b0); chk("br2_c1", 32'(o2), 32'(FLUSH_O)); chk("br3_c1", 32'(o3), 32'(FLUSH_O));
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("br2_c2", 32'(o2), 32'(FLUSH_O)); chk("br3_c2", 32'(o3), 32'(FLUSH_O));
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("br2_end", 32'(o2), 32'(RUN_O)); chk("br3_c3", 32'(o3), 32'(FLUSH_O));
    chk("br2_fc", 32'(fc2), ecnt(2));
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("br3_end", 32'(o3), 32'(RUN_O));
    chk("br3_fc", 32'(fc3), ecnt(3)); chk("br2_sc", 32'(sc2), ecnt(2));

    // memory freeze wins over branch and hazard
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1); chk("freeze", 32'(o2), 32'(FREEZE_O));
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0); chk("memw_exit2", 32'(o2), 32'(RUN_O)); chk("memw_exit3", 32'(o3), 32'(RUN_O));
    chk("memw_sc", 32'(sc2), ecnt(3)); chk("memw_fc", 32'(fc2), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("memw_after", 32'(o2), 32'(RUN_O));

    // watchdog: 8 stall cycles then forced release
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0); chk("wd_stall", 32'(o2), 32'(STALL_O));
    end
    chk("wd_pre", 32'(wd2), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); chk("wd_release", 32'(o2), 32'(RUN_O));
    drive(1'b1, 1'b1, 1'b0, 1'b0); chk("wd_restall", 32'(o2), 32'(STALL_O)); chk("wd_set", 32'(wd2), 32'd1);
    // branch kills a stalled instruction
    drive(1'b1, 1'b1, 1'b1, 1'b0); chk("haz_br", 32'(o2), 32'(FLUSH_O));
    chk("wd_sc", 32'(sc2), ecnt(9));
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("haz_br2", 32'(o2), 32'(FLUSH_O));
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("haz_br_end", 32'(o2), 32'(RUN_O)); chk("haz_br3", 32'(o3), 32'(FLUSH_O));
    chk("wd_sticky", 32'(wd2), 32'd1);

    // reset in the second FLUSH-state cycle of u3
    drive(1'b1, 1'b0, 1'b1, 1'b0); chk("rf_c1", 32'(o3), 32'(FLUSH_O));
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("rf_c2", 32'(o3), 32'(FLUSH_O));
    drive(1'b0, 1'b1, 1'b1, 1'b1); chk("rf_rst_out", 32'(o3), 32'(RUN_O));
    chk("rf_fc_pre", 32'(fc3), ecnt(5)); chk("rf_wd_pre", 32'(wd3), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("rf_after", 32'(o3), 32'(RUN_O));
    chk("rf_fc", 32'(fc3), 32'd0); chk("rf_sc", 32'(sc3), 32'd0); chk("rf_wd", 32'(wd3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
